// File: rtl/sd_block_reader.sv
// rtl/sd_block_reader.sv - SD DAT-line block receiver with per-line CRC16 check and byte FIFO
// Deserialises 1- or 4-line blocks into a byte stream, checks CRC and end bit, handles multi-block reads.

module sd_block_reader #(
    parameter int  DATA_LINES    = 4,
    parameter int  MAX_BLK_LEN   = 512,
    parameter int  START_TIMEOUT = 5000,
    parameter int  FIFO_DEPTH    = 4,
    localparam int LEN_W         = $clog2(MAX_BLK_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_sd_stb,
    input  logic [DATA_LINES-1:0] i_sd_data,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [LEN_W-1:0]      i_blk_len,
    input  logic [15:0]           i_blk_cnt,
    output logic                  o_sd_hold,
    output logic [7:0]            o_st_data,
    output logic                  o_st_vld,
    input  logic                  i_st_rdy,
    output logic                  o_st_sop,
    output logic                  o_st_eop,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [3:0]            o_status,
    output logic [DATA_LINES-1:0] o_crc_err_lines
);

    localparam int TO_W  = ($clog2(START_TIMEOUT + 1) > 16) ? $clog2(START_TIMEOUT + 1) : 16;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0]       BIT_LAST = 4'(8 / DATA_LINES - 1);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BLK_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_DATA,
        S_CRC,
        S_END_BIT
    } state_t;

    state_t                  state;
    logic [LEN_W-1:0]        blk_len;
    logic [LEN_W-1:0]        byte_cnt;
    logic [15:0]             blk_left;
    logic [TO_W-1:0]         to_cnt;
    logic [3:0]              bit_cnt;
    logic [7:0]              shreg;
    logic [15:0]             crc_calc [DATA_LINES];
    logic [15:0]             crc_rx   [DATA_LINES];
    logic [3:0]              status;
    logic [DATA_LINES-1:0]   crc_lines;
    logic                    done;
    logic                    push_vld;
    logic [9:0]              push_word;

    logic [9:0]              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt;
    logic [CNT_W-1:0]        fifo_cnt_nxt;
    logic                    sd_hold;
    logic                    pop;
    logic [7:0]              sh_next;
    logic [DATA_LINES-1:0]   mism;
    logic                    last_byte;
    logic                    fifo_full_nxt;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic [15:0] r;
        r = {crc[14:0], 1'b0};
        if (crc[15] ^ din) r = r ^ 16'h1021;
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop           = (fifo_cnt != '0) && i_st_rdy;
    assign fifo_cnt_nxt  = fifo_cnt + CNT_W'(push_vld) - CNT_W'(pop);
    assign fifo_full_nxt = (fifo_cnt_nxt == CNT_W'(FIFO_DEPTH));
    assign sh_next       = 8'({shreg, i_sd_data});
    assign last_byte     = (byte_cnt == blk_len - LEN_W'(1));

    always_comb begin
        mism = '0;
        for (int l = 0; l < DATA_LINES; l++) mism[l] = (crc_rx[l] != crc_calc[l]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            blk_len   <= '0;
            byte_cnt  <= '0;
            blk_left  <= '0;
            to_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            status    <= '0;
            crc_lines <= '0;
            done      <= 1'b0;
            push_vld  <= 1'b0;
            push_word <= '0;
            for (int l = 0; l < DATA_LINES; l++) begin
                crc_calc[l] <= '0;
                crc_rx[l]   <= '0;
            end
        end else begin
            done     <= 1'b0;
            push_vld <= 1'b0;
            if (i_abort) begin
                if (state != S_IDLE) begin
                    state     <= S_IDLE;
                    status[3] <= 1'b1;
                    done      <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start && fifo_cnt == '0 && !push_vld) begin
                            blk_len   <= (i_blk_len == '0) ? MAX_LEN : i_blk_len;
                            blk_left  <= (i_blk_cnt == 16'd0) ? 16'd1 : i_blk_cnt;
                            status    <= '0;
                            crc_lines <= '0;
                            to_cnt    <= '0;
                            byte_cnt  <= '0;
                            bit_cnt   <= '0;
                            for (int l = 0; l < DATA_LINES; l++) begin
                                crc_calc[l] <= '0;
                                crc_rx[l]   <= '0;
                            end
                            state <= S_WAIT_START;
                        end
                    end
                    S_WAIT_START: begin
                        if (i_sd_stb) begin
                            if (~|i_sd_data) begin
                                state    <= S_DATA;
                                to_cnt   <= '0;
                                bit_cnt  <= '0;
                                byte_cnt <= '0;
                            end else if (to_cnt == TO_W'(START_TIMEOUT - 1)) begin
                                to_cnt    <= TO_W'(START_TIMEOUT);
                                status[0] <= 1'b1;
                                done      <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                to_cnt <= to_cnt + TO_W'(1);
                            end
                        end
                    end
                    S_DATA: begin
                        if (i_sd_stb) begin
                            for (int l = 0; l < DATA_LINES; l++)
                                crc_calc[l] <= crc16_step(crc_calc[l], i_sd_data[l]);
                            shreg <= sh_next;
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                // No room for the byte: drop it and flag the transfer as corrupt.
                                if (fifo_full_nxt) begin
                                    status[1] <= 1'b1;
                                end else begin
                                    push_vld  <= 1'b1;
                                    push_word <= {byte_cnt == '0, last_byte, sh_next};
                                end
                                if (last_byte) begin
                                    byte_cnt <= '0;
                                    state    <= S_CRC;
                                end else begin
                                    byte_cnt <= byte_cnt + LEN_W'(1);
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_CRC: begin
                        if (i_sd_stb) begin
                            for (int l = 0; l < DATA_LINES; l++)
                                crc_rx[l] <= {crc_rx[l][14:0], i_sd_data[l]};
                            if (bit_cnt == 4'd15) begin
                                bit_cnt <= '0;
                                state   <= S_END_BIT;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_END_BIT: begin
                        if (i_sd_stb) begin
                            crc_lines <= crc_lines | mism;
                            if (|mism) status[1] <= 1'b1;
                            if (!(&i_sd_data)) status[2] <= 1'b1;
                            if ((|mism) || !(&i_sd_data) || status[1] || blk_left == 16'd1) begin
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                blk_left <= blk_left - 16'd1;
                                to_cnt   <= '0;
                                for (int l = 0; l < DATA_LINES; l++) begin
                                    crc_calc[l] <= '0;
                                    crc_rx[l]   <= '0;
                                end
                                state <= S_WAIT_START;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Abort flushes everything, including a byte still waiting in push_word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            sd_hold  <= 1'b0;
        end else if (i_abort) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            sd_hold  <= 1'b0;
        end else begin
            if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt_nxt;
            sd_hold  <= (fifo_cnt_nxt >= CNT_W'(FIFO_DEPTH - 2));
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld && !i_abort) fifo_mem[wr_ptr] <= push_word;
    end

    assign o_st_vld        = (fifo_cnt != '0);
    assign o_st_data       = o_st_vld ? fifo_mem[rd_ptr][7:0] : 8'h00;
    assign o_st_eop        = o_st_vld ? fifo_mem[rd_ptr][8] : 1'b0;
    assign o_st_sop        = o_st_vld ? fifo_mem[rd_ptr][9] : 1'b0;
    assign o_sd_hold       = sd_hold;
    assign o_busy          = (state != S_IDLE) || (fifo_cnt != '0) || push_vld;
    assign o_done          = done;
    assign o_status        = status;
    assign o_crc_err_lines = crc_lines;

endmodule
